// File: rtl/boundary_scan_register_bidir.sv
// Boundary-scan register for bidirectional pins: three cells per pin
// (control, output, input), shift-length counter and sticky length error.
// Optional build macro BSR_INTEST_EN turns mode 2'b10 into INTEST; when it is
// undefined, mode 2'b10 behaves as SAMPLE/PRELOAD.
module boundary_scan_register_bidir #(
   parameter int unsigned NUM_PINS = 8
) (
   input  logic                                  tck,
   input  logic                                  reset_n,
   input  logic                                  tdi,
   output logic                                  tdo,
   input  logic                                  select,
   input  logic                                  capture_dr,
   input  logic                                  shift_dr,
   input  logic                                  update_dr,
   input  logic [1:0]                            mode,
   input  logic [NUM_PINS-1:0]                   pad_in,
   output logic [NUM_PINS-1:0]                   pad_out,
   output logic [NUM_PINS-1:0]                   pad_oe,
   input  logic [NUM_PINS-1:0]                   core_out,
   input  logic [NUM_PINS-1:0]                   core_oe,
   output logic [NUM_PINS-1:0]                   core_in,
   output logic [$clog2(3*NUM_PINS+1)-1:0]       shift_count,
   output logic                                  shift_done,
   output logic                                  length_error
);

   localparam int unsigned L     = 3 * NUM_PINS;
   localparam int unsigned CNT_W = $clog2(L + 1);
   localparam logic [CNT_W-1:0] LEN = CNT_W'(L);

   localparam logic [1:0] ModeSample = 2'b00;
   localparam logic [1:0] ModeExtest = 2'b01;
   localparam logic [1:0] ModeIntest = 2'b10;
   localparam logic [1:0] ModeHighz  = 2'b11;

   logic [L-1:0] sr;
   logic [L-1:0] upd;
   logic [L-1:0] cap;

   // Capture vector laid out in the per-pin {input, output, control} cell order
   always_comb begin
      cap = '0;
      for (int k = 0; k < NUM_PINS; k++) begin
         cap[3*k]   = core_oe[k];
         cap[3*k+1] = core_out[k];
         cap[3*k+2] = pad_in[k];
      end
   end

   // Shift/update register and counters; capture beats shift beats update
   always_ff @(posedge tck or negedge reset_n) begin
      if (!reset_n) begin
         sr           <= '0;
         upd          <= '0;
         shift_count  <= '0;
         length_error <= 1'b0;
      end else if (select) begin
         if (capture_dr) begin
            sr           <= cap;
            shift_count  <= '0;
            length_error <= 1'b0;
         end else if (shift_dr) begin
            sr <= {sr[L-2:0], tdi};
            if (shift_count != LEN) begin
               shift_count <= shift_count + 1'b1;
            end
         end else if (update_dr) begin
            upd          <= sr;
            length_error <= (shift_count != LEN);
         end
      end
   end

   assign tdo        = sr[L-1];
   assign shift_done = (shift_count == LEN);

   // Pin muxing follows mode combinationally so a mode change acts at once
   always_comb begin
      pad_out = core_out;
      pad_oe  = core_oe;
      core_in = pad_in;
      case (mode)
         ModeExtest: begin
            for (int k = 0; k < NUM_PINS; k++) begin
               pad_out[k] = upd[3*k+1];
               pad_oe[k]  = upd[3*k];
            end
         end
         ModeHighz: begin
            pad_oe = '0;
         end
`ifdef BSR_INTEST_EN
         ModeIntest: begin
            pad_oe = '0;
            for (int k = 0; k < NUM_PINS; k++) begin
               core_in[k] = upd[3*k+2];
            end
         end
`endif
         ModeSample: ;
         default: ;
      endcase
   end

`ifndef BSR_INTEST_EN
   // Input update cells only feed the core in INTEST builds
   logic unused_in_cells;
   always_comb begin
      unused_in_cells = 1'b0;
      for (int k = 0; k < NUM_PINS; k++) begin
         unused_in_cells = unused_in_cells ^ upd[3*k+2];
      end
   end
`endif

endmodule

// File: tb/tb_boundary_scan_register_bidir.sv
// Directed bench for boundary_scan_register_bidir with NUM_PINS=4 (L=12).
// Expected values follow the build macro BSR_INTEST_EN for the INTEST case.
module tb_boundary_scan_register_bidir;

   localparam int unsigned NP = 4;

   logic       tck = 1'b0;
   logic       reset_n = 1'b0;
   logic       tdi = 1'b0;
   logic       tdo;
   logic       select = 1'b1;
   logic       capture_dr = 1'b0;
   logic       shift_dr = 1'b0;
   logic       update_dr = 1'b0;
   logic [1:0] mode = 2'b01;
   logic [NP-1:0] pad_in = '0;
   logic [NP-1:0] pad_out;
   logic [NP-1:0] pad_oe;
   logic [NP-1:0] core_out = '0;
   logic [NP-1:0] core_oe = '0;
   logic [NP-1:0] core_in;
   logic [3:0] shift_count;
   logic       shift_done;
   logic       length_error;

   int checks = 0;
   int errors = 0;

   boundary_scan_register_bidir #(.NUM_PINS(NP)) dut (
      .tck          (tck),
      .reset_n      (reset_n),
      .tdi          (tdi),
      .tdo          (tdo),
      .select       (select),
      .capture_dr   (capture_dr),
      .shift_dr     (shift_dr),
      .update_dr    (update_dr),
      .mode         (mode),
      .pad_in       (pad_in),
      .pad_out      (pad_out),
      .pad_oe       (pad_oe),
      .core_out     (core_out),
      .core_oe      (core_oe),
      .core_in      (core_in),
      .shift_count  (shift_count),
      .shift_done   (shift_done),
      .length_error (length_error)
   );

   always #5 tck = ~tck;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Drive strobes at the falling edge, return 1 time unit after the rising edge
   task automatic step(input logic c, input logic s, input logic u, input logic d);
      @(negedge tck);
      capture_dr = c;
      shift_dr   = s;
      update_dr  = u;
      tdi        = d;
      @(posedge tck);
      #1;
   endtask

   task automatic idle();
      @(negedge tck);
      capture_dr = 1'b0;
      shift_dr   = 1'b0;
      update_dr  = 1'b0;
      tdi        = 1'b0;
   endtask

   // Capture, shift 12 bits MSB first (ends with val in sr), then update
   task automatic load_upd(input logic [11:0] val);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 11; i >= 0; i--) step(1'b0, 1'b1, 1'b0, val[i]);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      idle();
   endtask

   logic [11:0] stream;
   logic [11:0] pats [2];
   logic [3:0]  exp_out [2];
   logic [3:0]  exp_oe [2];

   initial begin
      // Reset state
      repeat (2) @(negedge tck);
      reset_n = 1'b1;
      #1;
      check_val("rst_tdo", tdo, 0);
      check_val("rst_cnt", shift_count, 0);
      check_val("rst_done", shift_done, 0);
      check_val("rst_lerr", length_error, 0);
      check_val("rst_oe_extest", pad_oe, 4'b0000);

      // Reset mid-shift discards partial shift
      pad_in = 4'b1000;
      step(1'b1, 1'b0, 1'b0, 1'b0);
      check_val("pre_rst_tdo", tdo, 1);
      repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0);
      check_val("pre_rst_cnt", shift_count, 3);
      #2;
      reset_n = 1'b0;
      #1;
      check_val("async_rst_tdo", tdo, 0);
      check_val("async_rst_cnt", shift_count, 0);
      check_val("async_rst_oe", pad_oe, 4'b0000);
      idle();
      @(negedge tck);
      reset_n = 1'b1;
      repeat (2) @(posedge tck);
      #1;
      check_val("post_rst_cnt", shift_count, 0);
      check_val("post_rst_tdo", tdo, 0);

      // SAMPLE capture and shift-out
      mode     = 2'b00;
      pad_in   = 4'b1010;
      core_out = 4'b0110;
      core_oe  = 4'b1111;
      #1;
      check_val("sample_pad_out", pad_out, 4'b0110);
      check_val("sample_pad_oe", pad_oe, 4'b1111);
      check_val("sample_core_in", core_in, 4'b1010);
      stream = 12'b1010_1111_1001;
      step(1'b1, 1'b0, 1'b0, 1'b0);
      check_val("cap_tdo0", tdo, stream[11]);
      for (int i = 1; i <= 12; i++) begin
         step(1'b0, 1'b1, 1'b0, 1'b0);
         if (i <= 11) check_val($sformatf("shift_tdo%0d", i), tdo, stream[11-i]);
         if (i == 11) check_val("done_at_11", shift_done, 0);
      end
      check_val("cnt_at_12", shift_count, 12);
      check_val("done_at_12", shift_done, 1);
      check_val("tdo_after_12", tdo, 0);
      idle();

      // EXTEST preload and drive
      pats[0] = 12'h249; exp_out[0] = 4'b0000; exp_oe[0] = 4'b1111;
      pats[1] = 12'h492; exp_out[1] = 4'b1111; exp_oe[1] = 4'b0000;
      for (int p = 0; p < 2; p++) begin
         mode = 2'b00;
         load_upd(pats[p]);
         mode = 2'b01;
         #1;
         check_val($sformatf("extest_oe%0d", p), pad_oe, exp_oe[p]);
         check_val($sformatf("extest_out%0d", p), pad_out, exp_out[p]);
         check_val($sformatf("extest_core_in%0d", p), core_in, 4'b1010);
         check_val($sformatf("extest_lerr%0d", p), length_error, 0);
      end
      mode = 2'b11;
      #1;
      check_val("highz_oe", pad_oe, 4'b0000);
      check_val("highz_out", pad_out, 4'b0110);
      mode = 2'b01;

      // Length error: 11 shifts of 0 leaves sr=12'h800
      step(1'b1, 1'b0, 1'b0, 1'b0);
      repeat (11) step(1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      check_val("lerr_set", length_error, 1);
      check_val("lerr_upd_out", pad_out, 4'b0000);
      check_val("lerr_cnt_kept", shift_count, 11);
      idle();
      repeat (2) @(posedge tck);
      #1;
      check_val("lerr_sticky", length_error, 1);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      check_val("lerr_cleared", length_error, 0);
      check_val("cap_cnt_clr", shift_count, 0);
      repeat (15) step(1'b0, 1'b1, 1'b0, 1'b0);
      check_val("cnt_saturate", shift_count, 12);
      check_val("done_saturate", shift_done, 1);

      // Priority: capture wins over shift
      step(1'b1, 1'b1, 1'b0, 1'b0);
      check_val("prio_cnt", shift_count, 0);
      check_val("prio_tdo", tdo, 1);
      idle();
      select = 1'b0;
      repeat (5) step(1'b0, 1'b1, 1'b0, 1'b0);
      check_val("nosel_cnt", shift_count, 0);
      check_val("nosel_tdo", tdo, 1);
      idle();
      select = 1'b1;

      // INTEST: input cells set
      mode   = 2'b00;
      pad_in = 4'b0101;
      load_upd(12'h924);
      mode = 2'b10;
      #1;
`ifdef BSR_INTEST_EN
      check_val("intest_core_in", core_in, 4'b1111);
      check_val("intest_oe", pad_oe, 4'b0000);
`else
      check_val("intest_core_in", core_in, 4'b0101);
      check_val("intest_oe", pad_oe, 4'b1111);
`endif
      check_val("intest_out", pad_out, 4'b0110);
      mode = 2'b01;
      #1;
      check_val("after_intest_oe", pad_oe, 4'b0000);
      check_val("after_intest_core_in", core_in, 4'b0101);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
